// File: rtl/axis_rx_frame_capture_if.sv
// AXI-Stream sink bundle for the frame capture block.
// The source drives data and valid, and the capture block drives ready.
interface axis_rx_frame_capture_if #(
    parameter int AXI_DATA_WIDTH = 8
);
    localparam int KW = AXI_DATA_WIDTH / 8;

    logic [AXI_DATA_WIDTH-1:0] s_axis_tdata;
    logic [KW-1:0]             s_axis_tkeep;
    logic                      s_axis_tvalid;
    logic                      s_axis_tlast;
    logic                      s_axis_trdy;

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_trdy
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_trdy
    );
endinterface

// File: rtl/axis_rx_frame_capture.sv
// Captures one AXI-Stream frame into a beat buffer and holds it until acknowledged.
// Beats past the buffer depth are drained and flagged as overflow.
module axis_rx_frame_capture #(
    parameter int  AXI_DATA_WIDTH = 8,
    parameter int  DEPTH          = 256,
    parameter int  THROTTLE       = 0,
    localparam int KW             = AXI_DATA_WIDTH / 8,
    localparam int AW             = $clog2(DEPTH),
    localparam int LW             = $clog2(DEPTH * KW) + 1
) (
    input  logic                      m_aclk,
    input  logic                      m_sresetn,
    axis_rx_frame_capture_if.slave    s_axis,
    output logic                      frame_valid,
    output logic [LW-1:0]             frame_len,
    output logic                      frame_overflow,
    input  logic [AW-1:0]             rd_addr,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    input  logic                      frame_ack
);
    localparam int            TW      = (THROTTLE > 0) ? $clog2(THROTTLE + 1) : 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH * KW);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             wptr_q, wptr_d;
    logic [LW-1:0]             len_q, len_d, len_sum, last_bytes;
    logic [TW-1:0]             thr_q, thr_d;
    logic                      init_q, trdy_q, trdy_d, valid_q, ovf_q, ovf_d;
    logic                      xfer, wr_en, stall;
    logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AXI_DATA_WIDTH-1:0] rd_q;

    assign xfer               = s_axis.s_axis_tvalid && trdy_q;
    assign s_axis.s_axis_trdy = trdy_q;
    assign frame_valid        = valid_q;
    assign frame_len          = len_q;
    assign frame_overflow     = ovf_q;
    assign rd_data            = rd_q;

    always_comb begin
        last_bytes = '0;
        for (int i = 0; i < KW; i++) last_bytes = last_bytes + LW'(s_axis.s_axis_tkeep[i]);
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        wr_en   = 1'b0;
        len_sum = len_q + (s_axis.s_axis_tlast ? last_bytes : LW'(KW));
        if (len_sum > MAX_LEN) len_sum = MAX_LEN;

        case (state_q)
            IDLE, RECV: begin
                if (xfer) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    len_d  = len_sum;
                    if (s_axis.s_axis_tlast)             state_d = DONE;
                    else if (wptr_q == AW'(DEPTH - 1))   state_d = DRAIN;
                    else                                 state_d = RECV;
                end
            end
            DRAIN: if (xfer && s_axis.s_axis_tlast) state_d = DONE;
            DONE: begin
                if (frame_ack) begin
                    state_d = IDLE;
                    wptr_d  = '0;
                    len_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready is registered, so it is computed from the next counter value
        // to land low exactly on the cycle the counter sits at THROTTLE.
        thr_d  = (thr_q == TW'(THROTTLE)) ? '0 : thr_q + 1'b1;
        stall  = (THROTTLE > 0) && (thr_d == TW'(THROTTLE));
        trdy_d = init_q && (state_d != DONE) && !stall;
        ovf_d  = (state_d == DONE) && ((state_q == DRAIN) || ovf_q);
    end

    always_ff @(posedge m_aclk or negedge m_sresetn) begin
        if (!m_sresetn) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
            thr_q   <= '0;
            init_q  <= 1'b0;
            trdy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            thr_q   <= thr_d;
            init_q  <= 1'b1;
            trdy_q  <= trdy_d;
            valid_q <= (state_d == DONE);
            ovf_q   <= ovf_d;
            rd_q    <= mem_q[rd_addr];
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge m_aclk) begin
        if (wr_en) mem_q[wptr_q] <= s_axis.s_axis_tdata;
    end
endmodule

// File: tb/tb_axis_rx_frame_capture.sv
// Scoreboard bench: three capture instances (8b/16 deep, 32b/16 deep throttled, 8b/4 deep)
// share one stimulus bus; each frame's expected length/overflow/data is queued when driven.
module tb_axis_rx_frame_capture;
    localparam int NDUT = 3;

    typedef struct {
        int sel;
        int len;
        int ovf;
        int nbeats;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] dq[$];
    int          n_chk = 0;
    int          n_pass = 0;

    logic                       clk = 1'b0;
    logic [NDUT-1:0]            rst_n;
    logic [31:0]                tdata;
    logic [3:0]                 tkeep;
    logic                       tlast;
    logic [NDUT-1:0]            tvalid, ack;
    logic [3:0]                 rd_addr;
    logic [NDUT-1:0]            trdy, fv, fovf;
    logic [NDUT-1:0][7:0]       flen;
    logic [NDUT-1:0][31:0]      rdat;
    logic [4:0]                 flen_a;
    logic [6:0]                 flen_b;
    logic [2:0]                 flen_c;
    logic [7:0]                 rd_a, rd_c;
    logic [31:0]                rd_b;

    always #5 clk = ~clk;

    axis_rx_frame_capture_if #(.AXI_DATA_WIDTH(8))  if_a ();
    axis_rx_frame_capture_if #(.AXI_DATA_WIDTH(32)) if_b ();
    axis_rx_frame_capture_if #(.AXI_DATA_WIDTH(8))  if_c ();

    assign if_a.s_axis_tdata = tdata[7:0];  assign if_a.s_axis_tkeep = tkeep[0:0];
    assign if_a.s_axis_tvalid = tvalid[0];  assign if_a.s_axis_tlast = tlast;
    assign if_b.s_axis_tdata = tdata;       assign if_b.s_axis_tkeep = tkeep;
    assign if_b.s_axis_tvalid = tvalid[1];  assign if_b.s_axis_tlast = tlast;
    assign if_c.s_axis_tdata = tdata[7:0];  assign if_c.s_axis_tkeep = tkeep[0:0];
    assign if_c.s_axis_tvalid = tvalid[2];  assign if_c.s_axis_tlast = tlast;
    assign trdy = {if_c.s_axis_trdy, if_b.s_axis_trdy, if_a.s_axis_trdy};
    assign flen[0] = {3'b0, flen_a};
    assign flen[1] = {1'b0, flen_b};
    assign flen[2] = {5'b0, flen_c};
    assign rdat[0] = {24'b0, rd_a};
    assign rdat[1] = rd_b;
    assign rdat[2] = {24'b0, rd_c};

    axis_rx_frame_capture #(.AXI_DATA_WIDTH(8), .DEPTH(16), .THROTTLE(0)) u_a (
        .m_aclk(clk), .m_sresetn(rst_n[0]), .s_axis(if_a), .frame_valid(fv[0]),
        .frame_len(flen_a), .frame_overflow(fovf[0]), .rd_addr(rd_addr),
        .rd_data(rd_a), .frame_ack(ack[0]));
    axis_rx_frame_capture #(.AXI_DATA_WIDTH(32), .DEPTH(16), .THROTTLE(3)) u_b (
        .m_aclk(clk), .m_sresetn(rst_n[1]), .s_axis(if_b), .frame_valid(fv[1]),
        .frame_len(flen_b), .frame_overflow(fovf[1]), .rd_addr(rd_addr),
        .rd_data(rd_b), .frame_ack(ack[1]));
    axis_rx_frame_capture #(.AXI_DATA_WIDTH(8), .DEPTH(4), .THROTTLE(0)) u_c (
        .m_aclk(clk), .m_sresetn(rst_n[2]), .s_axis(if_c), .frame_valid(fv[2]),
        .frame_len(flen_c), .frame_overflow(fovf[2]), .rd_addr(rd_addr[1:0]),
        .rd_data(rd_c), .frame_ack(ack[2]));

    function automatic int kw_of(int sel);
        return (sel == 1) ? 4 : 1;
    endfunction

    function automatic int depth_of(int sel);
        return (sel == 2) ? 4 : 16;
    endfunction

    function automatic int popc(logic [3:0] k);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(k[i]);
        return n;
    endfunction

    task automatic chk(string tag, longint obs, longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drives one frame from a negedge; returns handshake count and clock edges used.
    task automatic send_frame(input int sel, input int n, input logic [3:0] lastkeep,
                              input logic [31:0] seed, output int hs, output int cyc);
        exp_t        e;
        int          kw = kw_of(sel);
        int          dep = depth_of(sel);
        logic [31:0] mask = (kw == 4) ? 32'hffff_ffff : 32'h0000_00ff;
        logic [3:0]  kmask = (kw == 4) ? 4'hf : 4'h1;
        logic [31:0] d;
        bit          ok;
        e.sel    = sel;
        e.nbeats = (n < dep) ? n : dep;
        e.ovf    = (n > dep) ? 1 : 0;
        e.len    = (n > dep) ? dep * kw : (n - 1) * kw + popc(lastkeep & kmask);
        sb.push_back(e);
        for (int i = 0; i < e.nbeats; i++) dq.push_back((((i + 1) * 32'h1111_1111) ^ seed) & mask);
        hs  = 0;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            d           = (((i + 1) * 32'h1111_1111) ^ seed) & mask;
            tdata       = d;
            tlast       = (i == n - 1);
            tkeep       = tlast ? lastkeep : 4'hf;
            tvalid[sel] = 1'b1;
            ok          = 1'b0;
            while (!ok && cyc < 200) begin
                ok = trdy[sel];
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            if (ok) hs++;
        end
        tvalid[sel] = 1'b0;
        tlast       = 1'b0;
        chk("handshakes", hs, n);
    endtask

    task automatic get_frame(input int sel);
        exp_t e;
        int   w = 0;
        while (!fv[sel] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("frame_valid", fv[sel], 1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("frame_len", flen[e.sel], e.len);
        chk("frame_overflow", fovf[e.sel], e.ovf);
        chk("trdy_in_done", trdy[e.sel], 0);
        for (int i = 0; i < e.nbeats; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            chk("rd_data", rdat[e.sel], dq.pop_front());
        end
        ack[sel] = 1'b1;
        @(negedge clk);
        ack[sel] = 1'b0;
        chk("valid_fall", fv[sel], 0);
        chk("overflow_clear", fovf[sel], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hs, cyc, lows, last_low, bad, n, k;
        rst_n = '0; tvalid = '0; ack = '0; tdata = '0; tkeep = '0; tlast = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < NDUT; s++) begin
            chk("rst_trdy", trdy[s], 0);
            chk("rst_valid", fv[s], 0);
            chk("rst_len", flen[s], 0);
            chk("rst_ovf", fovf[s], 0);
            chk("rst_rdata", rdat[s], 0);
        end
        rst_n = '1;
        @(negedge clk);
        chk("trdy_edge1_a", trdy[0], 0);
        chk("trdy_edge1_c", trdy[2], 0);
        @(negedge clk);
        chk("trdy_edge2_a", trdy[0], 1);
        chk("trdy_edge2_c", trdy[2], 1);

        // 5-byte frame 0x11..0x55
        send_frame(0, 5, 4'h1, 32'h0, hs, cyc);
        get_frame(0);

        // 32-bit partial last beat, zero keep, sparse keep
        send_frame(1, 3, 4'b0011, 32'h0, hs, cyc);
        get_frame(1);
        send_frame(1, 2, 4'b0000, 32'hdead_beef, hs, cyc);
        get_frame(1);
        send_frame(1, 2, 4'b0101, 32'h1234_5678, hs, cyc);
        get_frame(1);

        // Overflow into drain, then a frame exactly filling the buffer
        send_frame(2, 7, 4'h1, 32'h5a, hs, cyc);
        get_frame(2);
        send_frame(2, 4, 4'h1, 32'ha5, hs, cyc);
        get_frame(2);

        // Throttle: one low cycle in every four while idle
        repeat (2) @(negedge clk);
        lows = 0; last_low = -1; bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (!trdy[1]) begin
                if (last_low >= 0 && i - last_low != 4) bad++;
                last_low = i;
                lows++;
            end
            @(negedge clk);
        end
        chk("throttle_lows", lows, 4);
        chk("throttle_spacing", bad, 0);
        send_frame(1, 12, 4'hf, 32'h0f0f_0f0f, hs, cyc);
        chk("throttle_cycles_le16", (cyc <= 16) ? 1 : 0, 1);
        get_frame(1);

        // Random frames on the 8-bit instance
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 16);
            k = $urandom_range(0, 1);
            send_frame(0, n, 4'(k), $urandom, hs, cyc);
            get_frame(0);
        end

        // Reset mid-frame aborts it
        rd_addr = '0;
        tdata = 32'ha1; tkeep = 4'h1; tlast = 1'b0; tvalid[0] = 1'b1;
        @(negedge clk);
        tdata = 32'ha2;
        @(negedge clk);
        tvalid[0] = 1'b0;
        chk("abort_no_valid", fv[0], 0);
        chk("abort_partial_len", flen[0], 2);
        rst_n[0] = 1'b0;
        #1;
        chk("midrst_trdy", trdy[0], 0);
        chk("midrst_valid", fv[0], 0);
        chk("midrst_len", flen[0], 0);
        chk("midrst_ovf", fovf[0], 0);
        chk("midrst_rdata", rdat[0], 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_rst_valid", fv[0], 0);
        send_frame(0, 3, 4'h1, 32'h77, hs, cyc);
        get_frame(0);

        // Single-beat frame with ack in the same cycle: ack ignored
        ack[0] = 1'b1;
        send_frame(0, 1, 4'h1, 32'h3c, hs, cyc);
        ack[0] = 1'b0;
        chk("ack_ignored_valid", fv[0], 1);
        chk("ack_ignored_len", flen[0], 1);
        repeat (3) @(negedge clk);
        chk("valid_held", fv[0], 1);
        get_frame(0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
